pump_meter: RTL
===============

// Module: pump_meter
// PURPOSE
//  Customer-side pump/payment model that drives the gas_station controller's inputs.
//  - Collects coin credit and presents MONEY to the controller.
//  - Meters fuel while the controller asserts DELIVERGAS.
//  - Raises TANKFULL when the tank space is filled or the credit is spent.
//  - Sits between the pump hardware (coins, tank sensor) and the controller's
//    FEEDME/DELIVERGAS outputs.
// PARAMETERS
//  PRICE      3    credits consumed per fuel unit (1..MAX_CREDIT)
//  PULSE_DIV  4    clock cycles of DELIVERGAS per dispensed unit (>=1)
//  CREDIT_W   8    width of credit, space, unit and change counters
// PORTS
//  clock          in   1         system clock, rising edge
//  reset          in   1         synchronous, active-high
//  coin_in        in   1         1-cycle pulse = 1 credit
//  tank_space     in   CREDIT_W  free tank units; sampled on IDLE->COLLECT
//  FEEDME         in   1         controller requests payment
//  DELIVERGAS     in   1         controller is delivering fuel
//  MONEY          out  1         1-cycle pulse: payment sufficient
//  TANKFULL       out  1         level: stop fueling
//  credit         out  CREDIT_W  current credit
//  units          out  CREDIT_W  units dispensed this transaction
//  change_valid   out  1         1-cycle pulse in DONE
//  change         out  CREDIT_W  leftover credit; valid with change_valid
//  aborted        out  1         DELIVERGAS fell before TANKFULL; held until next IDLE->COLLECT
// BEHAVIOUR
//  Registers and outputs
//  - All outputs are registered.
//  - Reset drives state=IDLE and every output/counter to 0. Reset wins over all
//    inputs, including mid-transaction.
//  States: IDLE, COLLECT, FUEL, DONE.
//  IDLE
//  - credit, units and div_cnt held at 0.
//  - FEEDME=1 -> COLLECT: latch space<=tank_space, clear aborted.
//  COLLECT
//  - Each edge with coin_in=1: credit+1, saturating at 2^CREDIT_W-1.
//  - On the edge where credit>=PRICE and FEEDME=1: MONEY=1 for exactly one cycle,
//    next state is FUEL.
//  - A coin on that same edge still counts.
//  - FEEDME falling while in COLLECT -> DONE, with the collected credit returned as change.
//  FUEL
//  - coin_in is ignored.
//  - div_cnt counts edges with DELIVERGAS=1 and TANKFULL=0. When it reaches
//    PULSE_DIV-1 it wraps to 0 and, if credit>=PRICE and units<space, performs
//    units+1 and credit-PRICE.
//  - TANKFULL is registered. It goes to 1 on the edge after units==space or
//    credit<PRICE becomes true, including immediately on FUEL entry when space=0.
//  - TANKFULL holds until DELIVERGAS=0.
//  - DELIVERGAS=0 with TANKFULL=1 -> DONE.
//  - DELIVERGAS=0 with TANKFULL=0, after at least one cycle of DELIVERGAS=1
//    -> DONE with aborted=1 (emergency stop).
//  - While waiting for the first DELIVERGAS after MONEY, FUEL waits indefinitely.
//  DONE (one cycle)
//  - change<=credit, change_valid=1, TANKFULL<=0.
//  - Next state IDLE, where credit is cleared.
//  Arithmetic
//  - Unsigned throughout.
//  - The subtraction never underflows, because it is guarded by credit>=PRICE.
//  - units never exceeds space.
// TESTING
//  1. Assert reset for 2 cycles at any state -> every output is 0 and state=IDLE on the
//     following edge.
//  2. FEEDME=1 then 2 coins -> no MONEY. 3rd coin -> MONEY high for exactly 1 cycle,
//     credit=3, state FUEL.
//  3. credit=9, space=16, DELIVERGAS held high:
//     - units goes 1,2,3 at cycles 4,8,12.
//     - credit reaches 0 and TANKFULL rises on the next edge.
//     - Dropping DELIVERGAS gives change_valid with change=0 and aborted=0.
//  4. credit=30, space=2:
//     - TANKFULL rises after 2 units (8 cycles); DELIVERGAS drop -> change=24.
//     - space=0 variant: TANKFULL rises 1 cycle after FUEL entry, with units=0.
//  5. Emergency stop:
//     - credit=12, DELIVERGAS drops after 5 cycles -> aborted=1, units=1, change=9.
//     - Reset mid-FUEL -> all outputs cleared on the next edge.
//  6. 260 coin pulses in COLLECT -> credit saturates at 255, with no wrap to a small value.

Source files
------------

// File: rtl/pump_meter_if.sv
// Signal bundle between the pump/payment model and its environment
// (coin acceptor, tank sensor and gas_station controller).
interface pump_meter_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_in;
  logic [CREDIT_W-1:0] tank_space;
  logic                FEEDME;
  logic                DELIVERGAS;
  logic                MONEY;
  logic                TANKFULL;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] units;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                aborted;

  modport master (
    output coin_in, tank_space, FEEDME, DELIVERGAS,
    input  MONEY, TANKFULL, credit, units, change_valid, change, aborted
  );

  modport slave (
    input  coin_in, tank_space, FEEDME, DELIVERGAS,
    output MONEY, TANKFULL, credit, units, change_valid, change, aborted
  );
endinterface

// File: rtl/pump_meter.sv
// Customer-side pump model: collects coin credit, signals payment to the
// controller, meters fuel during DELIVERGAS and returns leftover credit.
module pump_meter #(
  parameter int PRICE     = 3,
  parameter int PULSE_DIV = 4,
  parameter int CREDIT_W  = 8
) (
  input  logic       clock,
  input  logic       reset,
  pump_meter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, FUEL, DONE} state_t;

  localparam int                  DIV_W    = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PULSE_DIV - 1);

  function automatic logic [CREDIT_W-1:0] sat_inc(input logic [CREDIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] units_q, units_d;
  logic [CREDIT_W-1:0] space_q, space_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                money_q, money_d;
  logic                tankfull_q, tankfull_d;
  logic                cv_q, cv_d;
  logic                aborted_q, aborted_d;
  logic                feed_q, feed_d;
  logic                seen_q, seen_d;

  logic can_pay, fill_stop, feed_fall, pulse, wrap;

  assign can_pay   = (credit_q >= PRICE_C);
  assign fill_stop = (units_q == space_q) || !can_pay;
  // feed_q only learns FEEDME inside COLLECT, so coins may be inserted with
  // FEEDME low and only a drop after FEEDME was seen high ends collection.
  assign feed_fall = feed_q && !bus.FEEDME;
  assign pulse     = bus.DELIVERGAS && !tankfull_q;
  assign wrap      = pulse && (div_q == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      units_q    <= '0;
      space_q    <= '0;
      change_q   <= '0;
      div_q      <= '0;
      money_q    <= 1'b0;
      tankfull_q <= 1'b0;
      cv_q       <= 1'b0;
      aborted_q  <= 1'b0;
      feed_q     <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      units_q    <= units_d;
      space_q    <= space_d;
      change_q   <= change_d;
      div_q      <= div_d;
      money_q    <= money_d;
      tankfull_q <= tankfull_d;
      cv_q       <= cv_d;
      aborted_q  <= aborted_d;
      feed_q     <= feed_d;
      seen_q     <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.FEEDME) state_d = COLLECT;
      COLLECT: begin
        if (can_pay && bus.FEEDME) state_d = FUEL;
        else if (feed_fall)        state_d = DONE;
      end
      FUEL:    if (!bus.DELIVERGAS && (tankfull_q || seen_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d   = credit_q;
    units_d    = units_q;
    space_d    = space_q;
    change_d   = change_q;
    div_d      = div_q;
    money_d    = 1'b0;
    tankfull_d = tankfull_q;
    cv_d       = 1'b0;
    aborted_d  = aborted_q;
    feed_d     = feed_q;
    seen_d     = seen_q;
    unique case (state_q)
      IDLE: begin
        credit_d = '0;
        units_d  = '0;
        div_d    = '0;
        if (bus.FEEDME) begin
          space_d   = bus.tank_space;
          aborted_d = 1'b0;
          feed_d    = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.coin_in) credit_d = sat_inc(credit_q);
        feed_d = bus.FEEDME;
        if (state_d == FUEL) begin
          money_d    = 1'b1;
          units_d    = '0;
          div_d      = '0;
          seen_d     = 1'b0;
          tankfull_d = 1'b0;
        end
      end
      FUEL: begin
        if (bus.DELIVERGAS) seen_d = 1'b1;
        if (pulse) div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap && can_pay && (units_q < space_q)) begin
          units_d  = units_q + 1'b1;
          credit_d = credit_q - PRICE_C;
        end
        tankfull_d = tankfull_q | fill_stop;
        if (state_d == DONE) aborted_d = !tankfull_q;
      end
      DONE: begin
        tankfull_d = 1'b0;
        credit_d   = '0;
        units_d    = '0;
        div_d      = '0;
      end
      default: ;
    endcase
    // change_valid is registered on DONE entry so it is high during DONE
    if ((state_d == DONE) && (state_q != DONE)) begin
      cv_d     = 1'b1;
      change_d = credit_d;
    end
  end

  assign bus.MONEY        = money_q;
  assign bus.TANKFULL     = tankfull_q;
  assign bus.credit       = credit_q;
  assign bus.units        = units_q;
  assign bus.change_valid = cv_q;
  assign bus.change       = change_q;
  assign bus.aborted      = aborted_q;

endmodule
